// File: rtl/riscv_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_mem_responder_pkg
// Description : Shared memory-system definitions: widths, responder FSM
//               state encoding and address helper.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_mem_responder_pkg;

    localparam int DATA_W  = 32;
    localparam int WADDR_W = 30;
    localparam int STATE_W = 3;
    localparam int MASK_W  = 4;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 3'd0,
        D_REQ  = 3'd1,
        D_WAIT = 3'd2,
        I_REQ  = 3'd3,
        I_WAIT = 3'd4
    } state_t;

    // Byte address to word address; the two lane bits are dropped.
    function automatic logic [WADDR_W-1:0] word_addr(input logic [DATA_W-1:0] byte_addr);
        return byte_addr[DATA_W-1:2];
    endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_mem_responder_ifetch_buf.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_buf
// Description : Single-entry instruction fetch buffer with lookup, fill on
//               fetch response and invalidate on a matching store.
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch_buf
    import riscv_mem_responder_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [WADDR_W-1:0] i_lookup_addr,
    output logic               o_hit,
    output logic [DATA_W-1:0]  o_data,
    input  logic               i_fill,
    input  logic [WADDR_W-1:0] i_fill_addr,
    input  logic [DATA_W-1:0]  i_fill_data,
    input  logic               i_inv,
    input  logic [WADDR_W-1:0] i_inv_addr
);

    logic               r_valid;
    logic [WADDR_W-1:0] r_addr;
    logic [DATA_W-1:0]  r_data;

    // Entry storage: fill and invalidate come from different FSM states,
    // so they never coincide.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
        end else if (i_fill) begin
            r_valid <= 1'b1;
            r_addr  <= i_fill_addr;
            r_data  <= i_fill_data;
        end else if (i_inv && (i_inv_addr == r_addr)) begin
            r_valid <= 1'b0;
        end
    end

    assign o_hit  = r_valid && (r_addr == i_lookup_addr);
    assign o_data = r_data;

endmodule
`default_nettype wire

// File: rtl/riscv_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : riscv_mem_responder
// Description : Bridges a CPU's instruction and data ports onto one backing
//               memory port. Data access first, then fetch; one request in
//               flight; single-entry fetch buffer short-circuits repeats.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_mem_responder
    import riscv_mem_responder_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [DATA_W-1:0]   icache_addr,
    input  logic                icache_re,
    input  logic [DATA_W-1:0]   dcache_addr,
    input  logic                dcache_re,
    input  logic [MASK_W-1:0]   dcache_we,
    input  logic [DATA_W-1:0]   dcache_din,
    output logic [DATA_W-1:0]   icache_dout,
    output logic [DATA_W-1:0]   dcache_dout,
    output logic                stall,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_req_rnw,
    output logic [WADDR_W-1:0]  mem_req_addr,
    output logic [MASK_W-1:0]   mem_req_wmask,
    output logic [DATA_W-1:0]   mem_req_data,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_resp_data
);

    state_t              r_state;
    state_t              w_next;

    logic [WADDR_W-1:0]  r_iaddr;
    logic                r_ire;
    logic [WADDR_W-1:0]  r_daddr;
    logic                r_dre;
    logic [MASK_W-1:0]   r_dwe;
    logic [DATA_W-1:0]   r_ddin;
    logic                r_fetch_pend;
    logic [DATA_W-1:0]   r_idout;
    logic [DATA_W-1:0]   r_ddout;

    logic [WADDR_W-1:0]  w_iwaddr;
    logic [WADDR_W-1:0]  w_dwaddr;
    logic                w_buf_hit;
    logic [DATA_W-1:0]   w_buf_data;
    logic                w_data_op;
    logic                w_fetch_pend;
    logic                w_is_write;
    logic                w_fill;
    logic                w_inv;
    logic                w_unused;

    assign w_iwaddr     = word_addr(icache_addr);
    assign w_dwaddr     = word_addr(dcache_addr);
    assign w_data_op    = (dcache_we != '0) || dcache_re;
    assign w_fetch_pend = icache_re && !w_buf_hit;
    assign w_is_write   = (r_dwe != '0);
    // Lane bits and the captured read strobes only matter through other paths.
    assign w_unused     = ^{icache_addr[1:0], dcache_addr[1:0], r_ire, r_dre};

    ifetch_buf u_ifetch_buf (
        .clk           (clk),
        .reset         (reset),
        .i_lookup_addr (w_iwaddr),
        .o_hit         (w_buf_hit),
        .o_data        (w_buf_data),
        .i_fill        (w_fill),
        .i_fill_addr   (r_iaddr),
        .i_fill_data   (mem_resp_data),
        .i_inv         (w_inv),
        .i_inv_addr    (r_daddr)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and memory-port drive; data access always precedes fetch.
    always_comb begin
        w_next        = r_state;
        mem_req_valid = 1'b0;
        mem_req_rnw   = 1'b1;
        mem_req_addr  = '0;
        mem_req_wmask = '0;
        mem_req_data  = '0;
        w_fill        = 1'b0;
        w_inv         = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_data_op) begin
                    w_next = D_REQ;
                end else if (w_fetch_pend) begin
                    w_next = I_REQ;
                end
            end
            D_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_rnw   = !w_is_write;
                mem_req_addr  = r_daddr;
                mem_req_wmask = r_dwe;
                mem_req_data  = r_ddin;
                if (mem_req_ready) begin
                    if (w_is_write) begin
                        w_inv  = 1'b1;
                        w_next = r_fetch_pend ? I_REQ : IDLE;
                    end else begin
                        w_next = D_WAIT;
                    end
                end
            end
            D_WAIT: begin
                if (mem_resp_valid) begin
                    w_next = r_fetch_pend ? I_REQ : IDLE;
                end
            end
            I_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = r_iaddr;
                if (mem_req_ready) begin
                    w_next = I_WAIT;
                end
            end
            I_WAIT: begin
                if (mem_resp_valid) begin
                    w_fill = 1'b1;
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Request capture in IDLE and response/hit loading of the output words.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_iaddr      <= '0;
            r_ire        <= 1'b0;
            r_daddr      <= '0;
            r_dre        <= 1'b0;
            r_dwe        <= '0;
            r_ddin       <= '0;
            r_fetch_pend <= 1'b0;
            r_idout      <= '0;
            r_ddout      <= '0;
        end else begin
            if (r_state == IDLE) begin
                r_iaddr      <= w_iwaddr;
                r_ire        <= icache_re;
                r_daddr      <= w_dwaddr;
                r_dre        <= dcache_re;
                r_dwe        <= dcache_we;
                r_ddin       <= dcache_din;
                r_fetch_pend <= w_fetch_pend;
                if (icache_re && w_buf_hit) begin
                    r_idout <= w_buf_data;
                end
            end
            if ((r_state == D_WAIT) && mem_resp_valid) begin
                r_ddout <= mem_resp_data;
            end
            if ((r_state == I_WAIT) && mem_resp_valid) begin
                r_idout <= mem_resp_data;
            end
        end
    end

    assign stall       = (r_state != IDLE);
    assign icache_dout = r_idout;
    assign dcache_dout = r_ddout;

endmodule
`default_nettype wire

// File: tb/tb_riscv_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_mem_responder
// Description : Self-checking bench: backing-memory responder process plus a
//               transaction-level reference model of the CPU-visible results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_mem_responder;

    typedef struct packed {
        logic        rnw;
        logic [29:0] addr;
        logic [3:0]  wmask;
        logic [31:0] data;
    } req_t;

    logic        clk;
    logic        reset;
    logic [31:0] icache_addr;
    logic        icache_re;
    logic [31:0] dcache_addr;
    logic        dcache_re;
    logic [3:0]  dcache_we;
    logic [31:0] dcache_din;
    logic [31:0] icache_dout;
    logic [31:0] dcache_dout;
    logic        stall;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_rnw;
    logic [29:0] mem_req_addr;
    logic [3:0]  mem_req_wmask;
    logic [31:0] mem_req_data;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;

    int n_checks = 0;
    int n_fail   = 0;

    // Memory process controls: 0 always ready, 1 random ready, 2 never ready.
    int   ready_mode  = 0;
    bit   inject_resp = 0;
    req_t acc_q[$];

    // Reference model state.
    logic [31:0] ref_mem [logic [29:0]];
    logic [31:0] bmem    [logic [29:0]];
    bit          bv;
    logic [29:0] baddr;
    logic [31:0] bdata;
    logic [31:0] exp_i;
    logic [31:0] exp_d;
    int          exp_stall;
    req_t        exp_q[$];

    riscv_mem_responder dut (
        .clk            (clk),
        .reset          (reset),
        .icache_addr    (icache_addr),
        .icache_re      (icache_re),
        .dcache_addr    (dcache_addr),
        .dcache_re      (dcache_re),
        .dcache_we      (dcache_we),
        .dcache_din     (dcache_din),
        .icache_dout    (icache_dout),
        .dcache_dout    (dcache_dout),
        .stall          (stall),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_rnw    (mem_req_rnw),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wmask  (mem_req_wmask),
        .mem_req_data   (mem_req_data),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input logic [29:0] a);
        return {a[13:0], a[17:0]} ^ 32'hA5C3_1E77;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [29:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_word(a);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // Backing memory: accepts at the edge where valid&ready, answers reads
    // in the following cycle, and watches held requests for stability.
    initial begin : mem_proc
        bit          pend;
        logic [29:0] pend_addr;
        bit          prev_valid;
        bit          prev_hs;
        req_t        prev_req;
        req_t        cur;
        pend = 0; pend_addr = '0; prev_valid = 0; prev_hs = 0; prev_req = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        forever begin
            @(negedge clk);
            cur = '{rnw: mem_req_rnw, addr: mem_req_addr, wmask: mem_req_wmask,
                    data: mem_req_rnw ? 32'h0 : mem_req_data};
            if (!reset) begin
                pend = 0; prev_valid = 0; prev_hs = 0;
            end else begin
                if (mem_req_valid && prev_valid && !prev_hs) begin
                    n_checks++;
                    if (cur !== prev_req) begin
                        n_fail++;
                        $display("FAIL req_stable: got %h expected %h", cur, prev_req);
                    end
                end
                prev_valid = mem_req_valid;
                prev_hs    = mem_req_valid && mem_req_ready;
                prev_req   = cur;
                if (mem_req_valid && mem_req_ready) begin
                    acc_q.push_back(cur);
                    if (mem_req_rnw) begin
                        pend = 1; pend_addr = mem_req_addr;
                    end else begin
                        bmem[mem_req_addr] = merge(bmem.exists(mem_req_addr) ?
                            bmem[mem_req_addr] : init_word(mem_req_addr), mem_req_data, mem_req_wmask);
                    end
                end
            end
            @(posedge clk);
            #1;
            if (pend && reset) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = bmem.exists(pend_addr) ? bmem[pend_addr] : init_word(pend_addr);
                pend = 0;
            end else if (inject_resp) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = 32'hBAD0_BAD0;
            end else begin
                mem_resp_valid = 1'b0;
                mem_resp_data  = $urandom;
            end
            case (ready_mode)
                0:       mem_req_ready = 1'b1;
                1:       mem_req_ready = 1'($urandom_range(0, 1));
                default: mem_req_ready = 1'b0;
            endcase
        end
    end

    task automatic preload(input logic [31:0] byte_addr, input logic [31:0] val);
        ref_mem[byte_addr[31:2]] = val;
        bmem[byte_addr[31:2]]    = val;
    endtask

    // Presents one CPU cycle of requests and predicts the outcome.
    task automatic cpu_issue(input logic [31:0] ia, input logic ire, input logic [31:0] da,
                             input logic dre, input logic [3:0] dwe, input logic [31:0] dd);
        bit hit;
        bit fetchp;
        acc_q.delete();
        exp_q.delete();
        exp_stall = 0;
        hit    = ire && bv && (baddr == ia[31:2]);
        fetchp = ire && !hit;
        if (hit) exp_i = bdata;
        if (dwe != 4'b0) begin
            exp_q.push_back('{rnw: 1'b0, addr: da[31:2], wmask: dwe, data: dd});
            ref_mem[da[31:2]] = merge(ref_rd(da[31:2]), dd, dwe);
            if (bv && baddr == da[31:2]) bv = 0;
            exp_stall = 1;
        end else if (dre) begin
            exp_q.push_back('{rnw: 1'b1, addr: da[31:2], wmask: 4'b0, data: 32'h0});
            exp_d = ref_rd(da[31:2]);
            exp_stall = 2;
        end
        if (fetchp) begin
            exp_q.push_back('{rnw: 1'b1, addr: ia[31:2], wmask: 4'b0, data: 32'h0});
            exp_i = ref_rd(ia[31:2]);
            bv = 1; baddr = ia[31:2]; bdata = exp_i;
            exp_stall += 2;
        end
        icache_addr = ia; icache_re = ire;
        dcache_addr = da; dcache_re = dre; dcache_we = dwe; dcache_din = dd;
        @(posedge clk);
        #1;
        icache_re = 1'b0; dcache_re = 1'b0; dcache_we = 4'b0;
        icache_addr = $urandom; dcache_addr = $urandom; dcache_din = $urandom;
    endtask

    // Waits out the stall and compares everything the CPU and memory saw.
    task automatic cpu_finish(input string name, input bit check_lat);
        int cyc;
        cyc = 0;
        while (stall === 1'b1 && cyc < 400) begin
            cyc++;
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_timeout: stall %b after %0d cycles, expected 0", name, stall, cyc);
        end
        n_checks++;
        if (icache_dout !== exp_i) begin
            n_fail++;
            $display("FAIL %s_icache_dout: got %h expected %h", name, icache_dout, exp_i);
        end
        n_checks++;
        if (dcache_dout !== exp_d) begin
            n_fail++;
            $display("FAIL %s_dcache_dout: got %h expected %h", name, dcache_dout, exp_d);
        end
        n_checks++;
        if (acc_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL %s_req_count: got %0d expected %0d", name, acc_q.size(), exp_q.size());
        end
        for (int k = 0; k < acc_q.size() && k < exp_q.size(); k++) begin
            n_checks++;
            if (acc_q[k] !== exp_q[k]) begin
                n_fail++;
                $display("FAIL %s_req%0d: got %h expected %h", name, k, acc_q[k], exp_q[k]);
            end
        end
        if (check_lat) begin
            n_checks++;
            if (cyc != exp_stall) begin
                n_fail++;
                $display("FAIL %s_latency: got %0d stall cycles expected %0d", name, cyc, exp_stall);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        icache_addr = '0; icache_re = 1'b0;
        dcache_addr = '0; dcache_re = 1'b0; dcache_we = 4'b0; dcache_din = '0;
        bv = 0; baddr = '0; bdata = '0; exp_i = '0; exp_d = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (stall !== 1'b0 || mem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: stall %b valid %b expected 0 0", stall, mem_req_valid);
        end
        n_checks++;
        if (icache_dout !== 32'h0 || dcache_dout !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_douts: got %h %h expected 0 0", icache_dout, dcache_dout);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_fetch_miss();
        preload(32'h2000, 32'h0000_0013);
        cpu_issue(32'h2000, 1'b1, 32'h0, 1'b0, 4'b0, 32'h0);
        cpu_finish("fetch_miss", 1'b1);
    endtask

    task automatic test_fetch_hit();
        cpu_issue(32'h2000, 1'b1, 32'h0, 1'b0, 4'b0, 32'h0);
        n_checks++;
        if (mem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_hit_valid: got %b expected 0", mem_req_valid);
        end
        cpu_finish("fetch_hit", 1'b1);
    endtask

    task automatic test_read_fetch();
        preload(32'h1004, 32'hDEAD_BEEF);
        preload(32'h2004, 32'h0010_0093);
        cpu_issue(32'h2004, 1'b1, 32'h1004, 1'b1, 4'b0, 32'h0);
        cpu_finish("read_fetch", 1'b1);
    endtask

    task automatic test_write_inval();
        cpu_issue(32'h2000, 1'b1, 32'h0, 1'b0, 4'b0, 32'h0);
        cpu_finish("refill_2000", 1'b1);
        cpu_issue(32'h2000, 1'b1, 32'h2000, 1'b0, 4'b0011, 32'h0000_ABCD);
        cpu_finish("write_hit", 1'b1);
        cpu_issue(32'h2000, 1'b1, 32'h0, 1'b0, 4'b0, 32'h0);
        cpu_finish("after_write", 1'b1);
    endtask

    task automatic test_stall_hold();
        preload(32'h3008, 32'h1234_5678);
        ready_mode = 2;
        repeat (2) @(posedge clk);
        #1;
        cpu_issue(32'h0, 1'b0, 32'h300A, 1'b1, 4'b0, 32'h0);
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (stall !== 1'b1 || mem_req_valid !== 1'b1 || mem_req_rnw !== 1'b1 ||
                mem_req_addr !== 30'(32'h3008 >> 2) || mem_req_wmask !== 4'b0) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: stall %b valid %b rnw %b addr %h wmask %b expected 1 1 1 %h 0",
                         k, stall, mem_req_valid, mem_req_rnw, mem_req_addr, mem_req_wmask,
                         30'(32'h3008 >> 2));
            end
            @(posedge clk);
            #1;
        end
        ready_mode = 0;
        cpu_finish("stall_hold", 1'b0);
    endtask

    task automatic test_spurious();
        inject_resp = 1;
        repeat (2) @(posedge clk);
        #1;
        inject_resp = 0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (icache_dout !== exp_i || dcache_dout !== exp_d || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL spurious_resp: got %h %h stall %b expected %h %h 0",
                     icache_dout, dcache_dout, stall, exp_i, exp_d);
        end
    endtask

    task automatic test_random();
        logic [31:0] ia;
        logic [31:0] da;
        logic [3:0]  dwe;
        logic        dre;
        int          op;
        ready_mode = 1;
        for (int t = 0; t < 60; t++) begin
            ia  = 32'h1000 * $urandom_range(1, 3) + 4 * $urandom_range(0, 2) + $urandom_range(0, 3);
            da  = 32'h1000 * $urandom_range(1, 3) + 4 * $urandom_range(0, 2) + $urandom_range(0, 3);
            op  = $urandom_range(0, 3);
            dre = (op == 1 || op == 3);
            dwe = (op >= 2) ? 4'($urandom_range(1, 15)) : 4'b0;
            cpu_issue(ia, 1'($urandom_range(0, 3) != 0), da, dre, dwe, $urandom);
            cpu_finish("random", 1'b0);
        end
        ready_mode = 0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        cpu_issue(32'h4000, 1'b1, 32'h0, 1'b0, 4'b0, 32'h0);
        n_checks++;
        if (mem_req_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_ireq_valid: got %b expected 1", mem_req_valid);
        end
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (stall !== 1'b0 || mem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_ctrl: stall %b valid %b expected 0 0", stall, mem_req_valid);
        end
        n_checks++;
        if (icache_dout !== 32'h0 || dcache_dout !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_reset_douts: got %h %h expected 0 0", icache_dout, dcache_dout);
        end
        bv = 0; exp_i = '0; exp_d = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        cpu_issue(32'h2000, 1'b1, 32'h0, 1'b0, 4'b0, 32'h0);
        cpu_finish("post_reset_fetch", 1'b1);
    endtask

    initial begin
        test_reset();
        test_fetch_miss();
        test_fetch_hit();
        test_read_fetch();
        test_write_inval();
        test_stall_hold();
        test_spurious();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
